// File: rtl/ysyx_22040632_riscv_pkg.sv
// Shared RISC-V core types: trap sequencer states, trap kinds and mcause encodings.
package ysyx_22040632_riscv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_MRET  = 2'd0,
    KIND_ECALL = 2'd1,
    KIND_INT   = 2'd2
  } trap_kind_e;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_22040632_trap_unit_if.sv
// Trap unit bundle: WB events, CSR enables/vectors in; CSR write pulses, pipeline control and IF redirect out.
interface ysyx_22040632_trap_unit_if #(
  parameter int XLEN = 64,
  parameter int PCW  = 32
);
  logic            wb_valid;
  logic [PCW-1:0]  wb_pc;
  logic            wb_ecall;
  logic            wb_mret;
  logic            mtip;
  logic            mstatus_mie_bit;
  logic            mie_mtie_bit;
  logic [PCW-1:0]  mtvec;
  logic [PCW-1:0]  mepc;
  logic            wen_ecall2csr;
  logic [XLEN-1:0] NO2csr;
  logic [PCW-1:0]  pc2csr;
  logic            wen_mstatus_ecall2csr;
  logic            wen_mstatus_mret2csr;
  logic            kill_wb;
  logic            flush;
  logic            stall_wb;
  logic            redirect_valid;
  logic [PCW-1:0]  redirect_pc;
  logic            redirect_ready;
  logic            busy;

  // master: the trap unit itself; slave: WB/CSR/IF environment around it
  modport master (
    input  wb_valid, wb_pc, wb_ecall, wb_mret, mtip, mstatus_mie_bit, mie_mtie_bit,
           mtvec, mepc, redirect_ready,
    output wen_ecall2csr, NO2csr, pc2csr, wen_mstatus_ecall2csr, wen_mstatus_mret2csr,
           kill_wb, flush, stall_wb, redirect_valid, redirect_pc, busy
  );

  modport slave (
    output wb_valid, wb_pc, wb_ecall, wb_mret, mtip, mstatus_mie_bit, mie_mtie_bit,
           mtvec, mepc, redirect_ready,
    input  wen_ecall2csr, NO2csr, pc2csr, wen_mstatus_ecall2csr, wen_mstatus_mret2csr,
           kill_wb, flush, stall_wb, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/ysyx_22040632_trap_arb.sv
// Combinational trap arbiter: interrupt > ecall > mret, only when WB holds a valid instruction.
module ysyx_22040632_trap_arb
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PCW  = 32
) (
  input  logic            wb_valid,
  input  logic            wb_ecall,
  input  logic            wb_mret,
  input  logic [PCW-1:0]  wb_pc,
  input  logic            mtip,
  input  logic            mstatus_mie_bit,
  input  logic            mie_mtie_bit,
  input  logic [PCW-1:0]  mtvec,
  input  logic [PCW-1:0]  mepc,
  output logic            take,
  output trap_kind_e      kind,
  output logic [XLEN-1:0] cause,
  output logic [PCW-1:0]  epc,
  output logic [PCW-1:0]  target
);
  logic           irq;
  logic [PCW-1:0] trap_vec;
  logic           unused_mode;

  assign irq         = mtip & mie_mtie_bit & mstatus_mie_bit;
  // direct mode only: the two mode bits never affect the vector
  assign trap_vec    = {mtvec[PCW-1:2], 2'b00};
  assign unused_mode = ^mtvec[1:0];

  always_comb begin
    take   = 1'b0;
    kind   = KIND_MRET;
    cause  = '0;
    epc    = '0;
    target = '0;
    if (wb_valid) begin
      if (irq) begin
        take   = 1'b1;
        kind   = KIND_INT;
        cause  = XLEN'(CAUSE_MTI);
        epc    = wb_pc;
        target = trap_vec;
      end else if (wb_ecall) begin
        take   = 1'b1;
        kind   = KIND_ECALL;
        cause  = XLEN'(CAUSE_ECALL_M);
        epc    = wb_pc;
        target = trap_vec;
      end else if (wb_mret) begin
        take   = 1'b1;
        kind   = KIND_MRET;
        target = mepc;
      end
    end
  end
endmodule

// File: rtl/ysyx_22040632_trap_unit.sv
// Trap sequencer: sample in IDLE (kill_wb same cycle), CSR pulses + flush next cycle, then hold
// redirect_valid until IF accepts; WB is stalled while busy, so no event is dropped.
module ysyx_22040632_trap_unit
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PCW  = 32
) (
  input logic                        clk,
  input logic                        rrst,
  ysyx_22040632_trap_unit_if.master  bus
);
  trap_state_e     state, state_n;
  trap_kind_e      kind_q, arb_kind;
  logic [XLEN-1:0] cause_q, arb_cause;
  logic [PCW-1:0]  epc_q, target_q, arb_epc, arb_target;
  logic            arb_take;
  logic            sample;

  ysyx_22040632_trap_arb #(.XLEN(XLEN), .PCW(PCW)) u_arb (
    .wb_valid        (bus.wb_valid),
    .wb_ecall        (bus.wb_ecall),
    .wb_mret         (bus.wb_mret),
    .wb_pc           (bus.wb_pc),
    .mtip            (bus.mtip),
    .mstatus_mie_bit (bus.mstatus_mie_bit),
    .mie_mtie_bit    (bus.mie_mtie_bit),
    .mtvec           (bus.mtvec),
    .mepc            (bus.mepc),
    .take            (arb_take),
    .kind            (arb_kind),
    .cause           (arb_cause),
    .epc             (arb_epc),
    .target          (arb_target)
  );

  assign sample = (state == IDLE) && arb_take;

  always_ff @(posedge clk) begin
    if (rrst) begin
      state    <= IDLE;
      kind_q   <= KIND_MRET;
      cause_q  <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      state <= state_n;
      if (sample) begin
        kind_q   <= arb_kind;
        cause_q  <= arb_cause;
        epc_q    <= arb_epc;
        target_q <= arb_target;
      end
    end
  end

  always_comb begin
    state_n                   = state;
    bus.kill_wb               = 1'b0;
    bus.wen_ecall2csr         = 1'b0;
    bus.wen_mstatus_ecall2csr = 1'b0;
    bus.wen_mstatus_mret2csr  = 1'b0;
    bus.flush                 = 1'b0;
    bus.stall_wb              = 1'b0;
    bus.busy                  = 1'b0;
    bus.redirect_valid        = 1'b0;
    bus.NO2csr                = '0;
    bus.pc2csr                = '0;
    bus.redirect_pc           = '0;
    // outputs are forced low during reset so an aborted COMMIT never pulses the CSR file
    if (!rrst) begin
      bus.NO2csr      = cause_q;
      bus.pc2csr      = epc_q;
      bus.redirect_pc = target_q;
      case (state)
        IDLE: begin
          if (arb_take) begin
            state_n     = COMMIT;
            bus.kill_wb = (arb_kind == KIND_INT);
          end
        end
        COMMIT: begin
          state_n      = REDIRECT;
          bus.flush    = 1'b1;
          bus.stall_wb = 1'b1;
          bus.busy     = 1'b1;
          if (kind_q == KIND_MRET) begin
            bus.wen_mstatus_mret2csr = 1'b1;
          end else begin
            bus.wen_ecall2csr         = 1'b1;
            bus.wen_mstatus_ecall2csr = 1'b1;
          end
        end
        REDIRECT: begin
          bus.redirect_valid = 1'b1;
          bus.stall_wb       = 1'b1;
          bus.busy           = 1'b1;
          if (bus.redirect_ready) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: doc/ysyx_22040632_trap_unit.md
# ysyx_22040632_trap_unit

Trap sequencer that drives the CSR file's trap-side write interface and the front-end redirect. It takes retiring ecall/mret events and the machine-timer pending line from WB/CLINT, arbitrates them, and issues the one-cycle CSR update pulses (`mepc`/`mcause`/`mstatus`). It then holds a flush-and-redirect handshake toward IF until accepted. It sits between WB, the CSR file and IF, and consumes the CSR file's `mstatus_mie_bit`, `mie_mtie_bit` and `mtvec` outputs.

## Interface
Parameters:
- `XLEN`, 64: CSR data width.
- `PCW`, 32: PC width.

Ports:
- `clk`  in  1  core clock.
- `rrst`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  WB holds a retiring instruction.
- `wb_pc`  in  PCW  PC of that instruction.
- `wb_ecall`  in  1  retiring instruction is ecall.
- `wb_mret`  in  1  retiring instruction is mret.
- `mtip`  in  1  machine timer pending, level.
- `mstatus_mie_bit`  in  1  global M interrupt enable, from CSR file.
- `mie_mtie_bit`  in  1  timer interrupt enable, from CSR file.
- `mtvec`  in  PCW  trap vector, from CSR file.
- `mepc`  in  PCW  return PC, from CSR file.
- `wen_ecall2csr`  out  1  write `mepc`/`mcause` pulse.
- `NO2csr`  out  XLEN  cause value for `mcause`.
- `pc2csr`  out  PCW  value for `mepc`.
- `wen_mstatus_ecall2csr`  out  1  trap-entry `mstatus` update pulse.
- `wen_mstatus_mret2csr`  out  1  mret `mstatus` update pulse.
- `kill_wb`  out  1  squash WB instruction; no register or memory commit.
- `flush`  out  1  flush IF/ID/EX.
- `stall_wb`  out  1  hold WB.
- `redirect_valid`  out  1  redirect request to IF.
- `redirect_pc`  out  PCW  redirect target.
- `redirect_ready`  in  1  IF accepts the redirect.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, COMMIT, REDIRECT.
- Event sampling happens only in IDLE and only with `wb_valid`=1.
- Priority: interrupt > ecall > mret.
- Interrupt condition: `mtip & mie_mtie_bit & mstatus_mie_bit`.
- Interrupt:
  - cause = `64'h8000_0000_0000_0007`.
  - epc = `wb_pc`.
  - `kill_wb`=1 in the sampling cycle, so the instruction re-executes after mret.
- Ecall:
  - cause = `64'd11`.
  - epc = `wb_pc`.
  - Ecall does not otherwise commit.
- Mret: no cause; epc is unused.
- Target is latched at sampling:
  - trap: `{mtvec[PCW-1:2],2'b00}`; direct mode only, mode bits are ignored.
  - mret: `mepc`.
- COMMIT, exactly one cycle:
  - trap: `wen_ecall2csr`=1 and `wen_mstatus_ecall2csr`=1, with `NO2csr`/`pc2csr` driven from latches.
  - mret: only `wen_mstatus_mret2csr`=1.
  - `flush`=1 in this cycle.
  - Next state is REDIRECT.
- REDIRECT: `redirect_valid`=1 with `redirect_pc` stable until `redirect_ready`. Return to IDLE the cycle after the handshake.
- `stall_wb`=1 and `busy`=1 in COMMIT and REDIRECT. New events are ignored there; WB is stalled, so none are lost.
- Interrupt with `mie`/`mtie`=0: ignored. `mtip` remains level and is re-evaluated every IDLE cycle.
- `wb_ecall` and `wb_mret` both set: treat as ecall.
- Event inputs without `wb_valid`: ignored.

## Timing
- Reset: state IDLE. All outputs are 0, including `NO2csr`, `pc2csr`, `redirect_pc` and `busy`.
- Reset in COMMIT or REDIRECT aborts the sequence. No CSR pulse is asserted in the reset cycle or after it.
- Event sampled at cycle T; `kill_wb` is combinational at T.
- CSR pulses and `flush` at T+1. The CSR file updates at the end of T+1.
- `redirect_valid` from T+2. Earliest return to IDLE is T+3, when `redirect_ready`=1 at T+2.
- Effective `mstatus.MIE` is 0 after a trap entry. Therefore no back-to-back interrupt is taken at T+3 unless software re-enables it.
- Minimum trap round trip is 3 cycles; it is unbounded while `redirect_ready`=0.

## Structure
- Shared package `ysyx_22040632_riscv_pkg` gains:
  - state enum `trap_state_e` {IDLE, COMMIT, REDIRECT};
  - `CAUSE_ECALL_M` (64'd11);
  - `CAUSE_MTI` (64'h8000_0000_0000_0007).
- One sub-module, `ysyx_22040632_trap_arb`: combinational priority arbiter producing take/kind/cause/epc/target from the WB inputs and CSR enables.
- The top module holds the FSM, latches and output registers.

## Test plan
- Ecall: `wb_ecall`, `wb_pc`=`32'h8000_0010`, `mtvec`=`32'h8000_0100` -> T+1 pulses with `NO2csr`=11 and `pc2csr`=`32'h8000_0010`; T+2 `redirect_pc`=`32'h8000_0100`.
- Mret: `mepc`=`32'h8000_0014` -> only `wen_mstatus_mret2csr` at T+1; redirect to `32'h8000_0014`.
- Interrupt:
  - `mtip`=1, MIE=MTIE=1, with `wb_ecall` at `32'h8000_0020` -> `kill_wb`=1 and cause `64'h8000_0000_0000_0007` with epc `32'h8000_0020`.
  - Same with MIE=0 -> ecall taken instead.
- Backpressure: `redirect_ready` held 0 for 5 cycles -> `redirect_valid` and `redirect_pc` stable; `stall_wb`=1 throughout; IDLE one cycle after ready.
- Reset in COMMIT -> next cycle all outputs 0 and state IDLE; no pulse in the reset cycle.
- Mask check: after an interrupt trap, the CSR model reports MIE=0 while `mtip` stays 1 -> no second trap.
